// File: rtl/wb_pkg_hdl.sv
// Shared definitions for the HDL-side Wishbone responder.
//   wb_resp_state_t : responder FSM states (IDLE, WAIT, RESP)
//   wb_lanes()      : number of byte lanes for a given data width
package wb_pkg_hdl;

  localparam int unsigned WB_LANE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_resp_state_t;

  function automatic int unsigned wb_lanes(input int unsigned data_width);
    return data_width / WB_LANE_BITS;
  endfunction

endpackage

// File: rtl/wb_resp_regfile.sv
// Register file behind the Wishbone responder.
//   clk, rst_n : clock, asynchronous active-low reset (clears every word)
//   wr_en      : write strobe; only lanes with wr_sel[i]=1 are updated
//   wr_idx     : word index for writes
//   wr_sel     : byte-lane enables
//   wr_data    : write data
//   rd_en      : read strobe; rd_data is loaded with the word, else cleared
//   rd_idx     : word index for reads
//   rd_data    : registered read data (zero on any cycle without rd_en)
module wb_resp_regfile
  import wb_pkg_hdl::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(DEPTH)-1:0]      wr_idx,
  input  logic [DATA_WIDTH/8-1:0]       wr_sel,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int unsigned BYTES = wb_lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wr_sel[b]) begin
          mem[wr_idx][b*WB_LANE_BITS +: WB_LANE_BITS] <= wr_data[b*WB_LANE_BITS +: WB_LANE_BITS];
        end
      end
    end
  end

  // Cleared when idle so the bus data output is zero outside read acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/wb_responder.sv
// Wishbone B3 classic-cycle responder with a byte-enabled register file.
//   clk, rst_n : clock, asynchronous active-low reset
//   cyc, stb   : request valid when both high
//   we         : 1 = write, 0 = read
//   adr        : byte address; in range when BASE_ADDR <= adr < BASE_ADDR+DEPTH*bytes
//   sel        : byte lanes for writes (ignored for reads)
//   dat_wr     : write data
//   dat_rd     : read data, non-zero only alongside a read ack
//   ack        : one-cycle normal termination
//   err        : one-cycle error termination (out-of-range address)
//   busy       : transaction in progress
module wb_responder
  import wb_pkg_hdl::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 16,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_wr,
  output logic [DATA_WIDTH-1:0]   dat_rd,
  output logic                    ack,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned           BYTES   = wb_lanes(DATA_WIDTH);
  localparam int unsigned           IDX_W   = $clog2(DEPTH);
  localparam int unsigned           OFS_W   = $clog2(BYTES);
  localparam logic [ADDR_WIDTH:0]   SPAN    = (ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [3:0]            WS_INIT = 4'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));

  wb_resp_state_t state, state_nxt;

  logic                    req;
  logic                    cap_we;
  logic [ADDR_WIDTH-1:0]   cap_adr;
  logic [DATA_WIDTH/8-1:0] cap_sel;
  logic [DATA_WIDTH-1:0]   cap_dat;
  logic [3:0]              cnt;

  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic [DATA_WIDTH/8-1:0] cur_sel;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic [ADDR_WIDTH-1:0]   cur_off;
  logic                    cur_hit;
  logic [IDX_W-1:0]        cur_idx;

  logic                    wr_en;
  logic                    rd_en;
  logic                    ack_d;
  logic                    err_d;
  logic                    busy_d;

  // In IDLE with no wait states the write commits on the capture edge
  // itself, so the live bus fields are used there; otherwise the captured
  // copies, which makes mid-transfer input changes irrelevant.
  always_comb begin
    req     = cyc & stb;
    cur_we  = (state == IDLE) ? we     : cap_we;
    cur_adr = (state == IDLE) ? adr    : cap_adr;
    cur_sel = (state == IDLE) ? sel    : cap_sel;
    cur_dat = (state == IDLE) ? dat_wr : cap_dat;
    cur_off = cur_adr - BASE_ADDR;
    cur_hit = (cur_adr >= BASE_ADDR) && ({1'b0, cur_off} < SPAN);
    cur_idx = cur_off[OFS_W +: IDX_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en  = (state_nxt == RESP) && cur_we && cur_hit;
    rd_en  = (state == RESP) && !cur_we && cur_hit;
    ack_d  = (state == RESP) && cur_hit;
    err_d  = (state == RESP) && !cur_hit;
    busy_d = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we  <= 1'b0;
      cap_adr <= '0;
      cap_sel <= '0;
      cap_dat <= '0;
      cnt     <= '0;
    end else if (state == IDLE && req) begin
      cap_we  <= we;
      cap_adr <= adr;
      cap_sel <= sel;
      cap_dat <= dat_wr;
      cnt     <= WS_INIT;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Responses are registered off the FSM state, so they appear in the
  // cycle after RESP, aligned with the registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      err  <= 1'b0;
      busy <= 1'b0;
    end else begin
      ack  <= ack_d;
      err  <= err_d;
      busy <= busy_d;
    end
  end

  wb_resp_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (cur_idx),
    .wr_sel  (cur_sel),
    .wr_data (cur_dat),
    .rd_en   (rd_en),
    .rd_idx  (cur_idx),
    .rd_data (dat_rd)
  );

endmodule

// File: tb/tb_wb_responder.sv
module tb_wb_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr    [2];
  logic [3:0]  sel    [2];
  logic [31:0] dat_wr [2];
  logic [31:0] dat_rd [2];
  logic [1:0]  ack, err, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]),
    .adr(adr[0]), .sel(sel[0]), .dat_wr(dat_wr[0]), .dat_rd(dat_rd[0]),
    .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );

  wb_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]),
    .adr(adr[1]), .sel(sel[1]), .dat_wr(dat_wr[1]), .dat_rd(dat_rd[1]),
    .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    logic        x_ack;
    logic        x_err;
    logic [31:0] x_dat;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance d; waits (bounded) for ack/err, then drops the
  // strobe and takes one more sample to check the pulse is single-cycle.
  // For the wait-state instance, bus fields are scrambled after capture.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      output logic g_ack, output logic g_err, output logic [31:0] g_dat,
                      output int lat, output int nbusy, output logic extra);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; sel[d] = s; dat_wr[d] = wd;
    g_ack = 1'b0; g_err = 1'b0; g_dat = '0; lat = -1; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1 && d == 1) begin
        adr[d] = ~a; sel[d] = ~s; dat_wr[d] = ~wd; we[d] = ~w;
      end
      if (busy[d]) nbusy++;
      if (ack[d] || err[d]) begin
        g_ack = ack[d]; g_err = err[d]; g_dat = dat_rd[d]; lat = k;
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    extra = ack[d] | err[d];
    if (busy[d]) nbusy++;
  endtask

  initial begin
    logic        g_ack, g_err, extra;
    logic [31:0] g_dat;
    int          lat, nbusy;

    tbl[0]  = '{1'b0, 32'h0000_0000, 4'b0000, 32'h0,          1'b1, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 32'h0000_0008, 4'b0101, 32'hDEAD_BEEF,  1'b1, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 32'h0000_0008, 4'b1111, 32'h0,          1'b1, 1'b0, 32'h00AD_00EF};
    tbl[3]  = '{1'b1, 32'h0000_0008, 4'b1010, 32'h1122_3344,  1'b1, 1'b0, 32'h0000_0000};
    tbl[4]  = '{1'b0, 32'h0000_0009, 4'b0000, 32'h0,          1'b1, 1'b0, 32'h11AD_33EF};
    tbl[5]  = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0,          1'b0, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b1, 32'h0000_0040, 4'b1111, 32'hFFFF_FFFF,  1'b0, 1'b1, 32'h0000_0000};
    tbl[7]  = '{1'b1, 32'h0000_003C, 4'b1111, 32'hCAFE_F00D,  1'b1, 1'b0, 32'h0000_0000};
    tbl[8]  = '{1'b0, 32'h0000_003C, 4'b1111, 32'h0,          1'b1, 1'b0, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 32'h0000_0000, 4'b0000, 32'hFFFF_FFFF,  1'b1, 1'b0, 32'h0000_0000};
    tbl[10] = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0,          1'b1, 1'b0, 32'h0000_0000};
    tbl[11] = '{1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0,          1'b0, 1'b1, 32'h0000_0000};
    tbl[12] = '{1'b1, 32'h0000_0004, 4'b1000, 32'hA500_0000,  1'b1, 1'b0, 32'h0000_0000};
    tbl[13] = '{1'b0, 32'h0000_0004, 4'b0001, 32'h0,          1'b1, 1'b0, 32'hA500_0000};
    tbl[14] = '{1'b0, 32'h0000_0008, 4'b1111, 32'h0,          1'b1, 1'b0, 32'h11AD_33EF};

    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0;
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; sel[d] = '0; dat_wr[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset ack d%0d", d),  32'(ack[d]),  32'h0);
      chk($sformatf("reset err d%0d", d),  32'(err[d]),  32'h0);
      chk($sformatf("reset busy d%0d", d), 32'(busy[d]), 32'h0);
      chk($sformatf("reset dat d%0d", d),  dat_rd[d],    32'h0);
    end
    rst_n = 1'b1;

    // Zero-wait-state instance: table of single transfers.
    for (int i = 0; i < 15; i++) begin
      xfer(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, g_ack, g_err, g_dat, lat, nbusy, extra);
      chk($sformatf("v%0d ack", i),     32'(g_ack), 32'(tbl[i].x_ack));
      chk($sformatf("v%0d err", i),     32'(g_err), 32'(tbl[i].x_err));
      chk($sformatf("v%0d dat", i),     g_dat,      tbl[i].x_dat);
      chk($sformatf("v%0d latency", i), 32'(lat),   32'd2);
      chk($sformatf("v%0d busy", i),    32'(nbusy), 32'd1);
      chk($sformatf("v%0d pulse", i),   32'(extra), 32'h0);
    end

    // Three wait states: write 0x4, latency and busy window.
    xfer(1, 1'b1, 32'h4, 4'hF, 32'hDEAD_0004, g_ack, g_err, g_dat, lat, nbusy, extra);
    chk("ws3 wr ack",     32'(g_ack), 32'h1);
    chk("ws3 wr err",     32'(g_err), 32'h0);
    chk("ws3 wr latency", 32'(lat),   32'd5);
    chk("ws3 wr busy",    32'(nbusy), 32'd4);
    chk("ws3 wr pulse",   32'(extra), 32'h0);
    xfer(1, 1'b0, 32'h4, 4'h0, 32'h0, g_ack, g_err, g_dat, lat, nbusy, extra);
    chk("ws3 rd ack",     32'(g_ack), 32'h1);
    chk("ws3 rd dat",     g_dat,      32'hDEAD_0004);
    chk("ws3 rd latency", 32'(lat),   32'd5);

    // Abort: cyc dropped after one wait cycle during a write to 0xC.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'hC; sel[1] = 4'hF; dat_wr[1] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    g_ack = 1'b0; g_err = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      g_ack = g_ack | ack[1];
      g_err = g_err | err[1];
    end
    chk("abort ack", 32'(g_ack), 32'h0);
    chk("abort err", 32'(g_err), 32'h0);
    xfer(1, 1'b0, 32'hC, 4'hF, 32'h0, g_ack, g_err, g_dat, lat, nbusy, extra);
    chk("abort rd ack", 32'(g_ack), 32'h1);
    chk("abort rd dat", g_dat,      32'h0);

    // Reset during WAIT after earlier writes.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h8; sel[1] = 4'hF; dat_wr[1] = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset busy", 32'(busy[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async rst ack",  32'(ack[1]),  32'h0);
    chk("async rst err",  32'(err[1]),  32'h0);
    chk("async rst busy", 32'(busy[1]), 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 16; w++) begin
      xfer(1, 1'b0, 32'(w * 4), 4'hF, 32'h0, g_ack, g_err, g_dat, lat, nbusy, extra);
      chk($sformatf("post-rst d3 w%0d ack", w), 32'(g_ack), 32'h1);
      chk($sformatf("post-rst d3 w%0d dat", w), g_dat,      32'h0);
    end
    xfer(0, 1'b0, 32'h8, 4'hF, 32'h0, g_ack, g_err, g_dat, lat, nbusy, extra);
    chk("post-rst d0 0x8",  g_dat, 32'h0);
    xfer(0, 1'b0, 32'h3C, 4'hF, 32'h0, g_ack, g_err, g_dat, lat, nbusy, extra);
    chk("post-rst d0 0x3C", g_dat, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
